// File: rtl/rf_write_scheduler_if.sv
// Write-request bundle for rf_write_scheduler: two producer ports sharing one RF write port.
// Handshake: a port transfers on a rising edge where valid & ready; ready depends only on
// scheduler state, valid must not wait on ready, and addr/data are sampled only on transfer.
interface rf_write_scheduler_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          wr0_valid;
    logic          wr0_ready;
    logic [AW-1:0] wr0_addr;
    logic [DW-1:0] wr0_data;
    logic          wr1_valid;
    logic          wr1_ready;
    logic [AW-1:0] wr1_addr;
    logic [DW-1:0] wr1_data;

    modport master (
        output wr0_valid, wr0_addr, wr0_data,
        output wr1_valid, wr1_addr, wr1_data,
        input  wr0_ready, wr1_ready
    );

    modport slave (
        input  wr0_valid, wr0_addr, wr0_data,
        input  wr1_valid, wr1_addr, wr1_data,
        output wr0_ready, wr1_ready
    );
endinterface

// File: rtl/rf_write_scheduler.sv
// Serialises two writeback producers onto one registered RF write port and reports pending
// destinations for hazard detection. Optional forwarding is enabled by RF_WB_BYPASS_EN.
module rf_write_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    rf_write_scheduler_if.slave          wr,
    output logic                         rf_we,
    output logic [AW-1:0]                rf_waddr,
    output logic [DW-1:0]                rf_wdata,
    input  logic [AW-1:0]                rd_addr_a,
    input  logic [AW-1:0]                rd_addr_b,
    output logic                         hazard_a,
    output logic                         hazard_b,
    output logic                         fwd_valid_a,
    output logic                         fwd_valid_b,
    output logic [DW-1:0]                fwd_data_a,
    output logic [DW-1:0]                fwd_data_b,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_1;
    logic [OW-1:0] free;
    logic          push0;
    logic          push1;
    logic          pop;
    logic [PW-1:0] idx_h;

    assign free         = OW'(DEPTH) - occupancy;
    assign wr.wr0_ready = (free >= OW'(1));
    assign wr.wr1_ready = (free >= OW'(2));

    // Address 0 is a hardwired zero register: the request is accepted but never stored.
    assign push0  = wr.wr0_valid && wr.wr0_ready && (wr.wr0_addr != '0);
    assign push1  = wr.wr1_valid && wr.wr1_ready && (wr.wr1_addr != '0);
    assign pop    = (occupancy != '0);
    assign tail_1 = push0 ? PW'(tail + PW'(1)) : tail;

    always_ff @(posedge clk) begin
        if (push0) begin
            addr_q[tail] <= wr.wr0_addr;
            data_q[tail] <= wr.wr0_data;
        end
        if (push1) begin
            addr_q[tail_1] <= wr.wr1_addr;
            data_q[tail_1] <= wr.wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            tail      <= PW'(tail + PW'(push0) + PW'(push1));
            occupancy <= OW'(occupancy + OW'(push0) + OW'(push1) - OW'(pop));
            if (pop) begin
                head     <= PW'(head + PW'(1));
                rf_we    <= 1'b1;
                rf_waddr <= addr_q[head];
                rf_wdata <= data_q[head];
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    always_comb begin
        hazard_a = rf_we && (rf_waddr == rd_addr_a);
        hazard_b = rf_we && (rf_waddr == rd_addr_b);
        idx_h    = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx_h = PW'(head + PW'(i));
            if (i < int'(occupancy)) begin
                if (addr_q[idx_h] == rd_addr_a) hazard_a = 1'b1;
                if (addr_q[idx_h] == rd_addr_b) hazard_b = 1'b1;
            end
        end
        hazard_a = hazard_a && (rd_addr_a != '0);
        hazard_b = hazard_b && (rd_addr_b != '0);
    end

`ifdef RF_WB_BYPASS_EN
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic [PW-1:0] idx_f;

    // Scan oldest to newest so the youngest matching entry overrides older ones.
    always_comb begin
        data_a = '0;
        data_b = '0;
        idx_f  = head;
        if (rf_we && (rf_waddr == rd_addr_a)) data_a = rf_wdata;
        if (rf_we && (rf_waddr == rd_addr_b)) data_b = rf_wdata;
        for (int i = 0; i < DEPTH; i++) begin
            idx_f = PW'(head + PW'(i));
            if (i < int'(occupancy)) begin
                if (addr_q[idx_f] == rd_addr_a) data_a = data_q[idx_f];
                if (addr_q[idx_f] == rd_addr_b) data_b = data_q[idx_f];
            end
        end
    end

    assign fwd_valid_a = hazard_a;
    assign fwd_valid_b = hazard_b;
    assign fwd_data_a  = hazard_a ? data_a : '0;
    assign fwd_data_b  = hazard_b ? data_b : '0;
`else
    assign fwd_valid_a = 1'b0;
    assign fwd_valid_b = 1'b0;
    assign fwd_data_a  = '0;
    assign fwd_data_b  = '0;
`endif
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: directed scenarios plus random traffic,
// with a queue of expected RF writes and a pending-set model for hazard/forward outputs.
module tb_rf_write_scheduler;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          hazard_a;
    logic          hazard_b;
    logic          fwd_valid_a;
    logic          fwd_valid_b;
    logic [DW-1:0] fwd_data_a;
    logic [DW-1:0] fwd_data_b;
    logic [OW-1:0] occupancy;

    logic [AW+DW-1:0] exp_q[$];
    int n_checks;
    int n_errors;
    int m_occ;

    rf_write_scheduler_if #(.AW(AW), .DW(DW)) bus ();

    rf_write_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (bus),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .fwd_valid_a (fwd_valid_a),
        .fwd_valid_b (fwd_valid_b),
        .fwd_data_a  (fwd_data_a),
        .fwd_data_b  (fwd_data_b),
        .occupancy   (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expd);
        n_checks++;
        if (act !== expd) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expd);
        end
    endtask

    // RF write monitor: every rf_we cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [AW+DW-1:0] item;
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", rf_we, 1'b0);
            end else begin
                item = exp_q.pop_front();
                check("rf_waddr", rf_waddr, item[AW+DW-1:DW]);
                check("rf_wdata", rf_wdata, item[DW-1:0]);
            end
        end
    end

    // Outstanding expectations at this point equal the DUT's pending set, oldest first.
    task automatic check_one_port(input string tag, input logic [AW-1:0] ra, input logic haz,
                                  input logic fv, input logic [DW-1:0] fd);
        logic          exp_haz;
        logic [DW-1:0] exp_data;
        logic [AW+DW-1:0] e;
        exp_haz  = 1'b0;
        exp_data = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            if (ra != '0 && e[AW+DW-1:DW] == ra) begin
                exp_haz  = 1'b1;
                exp_data = e[DW-1:0];
            end
        end
        check({tag, "_hazard"}, haz, exp_haz);
`ifdef RF_WB_BYPASS_EN
        check({tag, "_fwd_valid"}, fv, exp_haz);
        if (exp_haz) check({tag, "_fwd_data"}, fd, exp_data);
`else
        check({tag, "_fwd_valid"}, fv, 1'b0);
        check({tag, "_fwd_data"}, fd, '0);
`endif
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic r0;
        logic r1;
        int   pushes;
        r0 = (m_occ < DEPTH);
        r1 = (m_occ + 2 <= DEPTH);
        check("wr0_ready", bus.wr0_ready, r0);
        check("wr1_ready", bus.wr1_ready, r1);
        bus.wr0_valid = v0;
        bus.wr0_addr  = a0;
        bus.wr0_data  = d0;
        bus.wr1_valid = v1;
        bus.wr1_addr  = a1;
        bus.wr1_data  = d1;
        pushes = 0;
        if (v0 && r0 && a0 != '0) begin exp_q.push_back({a0, d0}); pushes++; end
        if (v1 && r1 && a1 != '0) begin exp_q.push_back({a1, d1}); pushes++; end
        @(posedge clk);
        #1;
        m_occ = m_occ + pushes - ((m_occ != 0) ? 1 : 0);
        bus.wr0_valid = 1'b0;
        bus.wr1_valid = 1'b0;
        check("occupancy", occupancy, m_occ);
        check_one_port("port_a", rd_addr_a, hazard_a, fwd_valid_a, fwd_data_a);
        check_one_port("port_b", rd_addr_b, hazard_b, fwd_valid_b, fwd_data_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_occ    = 0;
        reset    = 1'b1;
        bus.wr0_valid = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_valid = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_rf_we", rf_we, 1'b0);
        check("reset_rf_waddr", rf_waddr, '0);
        check("reset_rf_wdata", rf_wdata, '0);
        check("reset_occupancy", occupancy, '0);

        // Single write: visible on the RF port one cycle after acceptance.
        rd_addr_a = 4'd5;
        drive(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        check("t1_we_not_yet", rf_we, 1'b0);
        check("t1_haz_queued", hazard_a, 1'b1);
        idle(1);
        check("t1_we", rf_we, 1'b1);
        check("t1_waddr", rf_waddr, 4'd5);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
        check("t1_haz_output", hazard_a, 1'b1);
        idle(1);
        check("t1_we_drop", rf_we, 1'b0);
        check("t1_haz_clear", hazard_a, 1'b0);

        // Dual same-cycle request: port 0 retires first.
        drive(1'b1, 4'd3, 32'h11, 1'b1, 4'd7, 32'h22);
        idle(1);
        check("t2_first", rf_waddr, 4'd3);
        idle(1);
        check("t2_second", rf_waddr, 4'd7);
        check("t2_second_we", rf_we, 1'b1);
        idle(1);
        check("t2_done", rf_we, 1'b0);

        // Fill: dual pushes outpace the single retire until port 1 backs off.
        drive(1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h102);
        drive(1'b1, 4'd3, 32'h103, 1'b1, 4'd4, 32'h104);
        check("t3_occ3", occupancy, 3'd3);
        check("t3_wr1_blocked", bus.wr1_ready, 1'b0);
        check("t3_wr0_open", bus.wr0_ready, 1'b1);
        drive(1'b1, 4'd5, 32'h105, 1'b1, 4'd6, 32'h106);
        drive(1'b1, 4'd7, 32'h107, 1'b1, 4'd8, 32'h108);
        idle(5);
        check("t3_drained", exp_q.size(), 0);

        // Address 0 is accepted but never written and never hazards.
        rd_addr_a = '0;
        drive(1'b1, '0, 32'hAAAA, 1'b1, '0, 32'hBBBB);
        check("t4_occ", occupancy, '0);
        check("t4_haz", hazard_a, 1'b0);
        idle(1);
        check("t4_we", rf_we, 1'b0);

        // Reset with a loaded queue discards everything, including a same-cycle request.
        drive(1'b1, 4'd8, 32'h208, 1'b1, 4'd9, 32'h209);
        drive(1'b1, 4'd10, 32'h20A, 1'b1, 4'd11, 32'h20B);
        check("t5_occ_before", occupancy, 3'd3);
        reset = 1'b1;
        bus.wr0_valid = 1'b1; bus.wr0_addr = 4'd6; bus.wr0_data = 32'h206;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.wr0_valid = 1'b0;
        exp_q.delete();
        m_occ = 0;
        check("t5_we", rf_we, 1'b0);
        check("t5_occ", occupancy, '0);
        check("t5_waddr", rf_waddr, '0);
        check("t5_wr0_ready", bus.wr0_ready, 1'b1);
        check("t5_wr1_ready", bus.wr1_ready, 1'b1);
        idle(3);

        // Forwarding: youngest pending value wins, including output-stage-only matches.
        rd_addr_a = 4'd9;
        rd_addr_b = 4'd9;
        drive(1'b1, 4'd9, 32'hA, 1'b1, 4'd9, 32'hB);
        check("t6_haz_a", hazard_a, 1'b1);
`ifdef RF_WB_BYPASS_EN
        check("t6_fwd_valid", fwd_valid_a, 1'b1);
        check("t6_fwd_data", fwd_data_a, 32'hB);
`else
        check("t6_fwd_valid", fwd_valid_a, 1'b0);
        check("t6_fwd_data", fwd_data_a, 32'h0);
`endif
        idle(3);
        rd_addr_b = 4'd4;
        drive(1'b1, 4'd9, 32'hA, 1'b0, '0, '0);
        drive(1'b1, 4'd4, 32'hC, 1'b0, '0, '0);
`ifdef RF_WB_BYPASS_EN
        check("t6_fwd_out_stage", fwd_data_a, 32'hA);
        check("t6_fwd_queue", fwd_data_b, 32'hC);
`else
        check("t6_haz_b", hazard_b, 1'b1);
`endif
        idle(3);

        // Random traffic, including address 0 and back-pressure.
        for (int n = 0; n < 400; n++) begin
            rd_addr_a = AW'($urandom_range(0, 15));
            rd_addr_b = AW'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        end
        idle(6);
        check("final_drained", exp_q.size(), 0);
        check("final_occ", occupancy, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
